branch_ctrl: RTL
================

# branch_ctrl

Branch resolution controller for the pipelined core: owns a small direct-mapped branch history table (BHT) of 2-bit saturating counters. It predicts at fetch, and gates the EX-stage branch unit so that unit evaluates only real conditional branches. It compares the resolved outcome with the carried prediction and, on a mispredict, flushes the wrong path and hands a corrected PC to fetch over a valid/ready handshake.

## Interface
- XLEN, 32, datapath / PC width
- BHT_IDX, 4, BHT index width; the BHT has 2^BHT_IDX entries
- CNT_W, 16, mispredict counter width

- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- IF_PC  in  XLEN  fetch-stage PC used for lookup
- Pred_taken  out  1  prediction for IF_PC
- EX_Branch  in  1  EX stage holds a valid conditional branch
- EX_PC  in  XLEN  PC of the EX-stage branch
- EX_Imm  in  XLEN  sign-extended B-type immediate
- EX_Pred  in  1  Pred_taken value carried down the pipe with this branch
- BU_En  out  1  enable to the branch unit
- BU_Taken  in  1  branch-unit decision (valid only while BU_En=1)
- Redirect_valid  out  1  corrected PC offered to fetch
- Redirect_PC  out  XLEN  corrected PC
- Redirect_ready  in  1  fetch accepts the redirect
- Flush  out  1  kill IF/ID and ID/EX contents this cycle
- Stall  out  1  hold PC and pipeline registers
- Miss_Cnt  out  CNT_W  saturating mispredict count

## Operation
- Index rule: idx(pc) = pc[BHT_IDX+1:2].
- Pred_taken = MSB of BHT[idx(IF_PC)].
- Counter reset value is 2'b01 (weakly not-taken) for every entry.

FSM states:
- IDLE
  - BU_En = EX_Branch.
  - If EX_Branch = 1:
    - update BHT[idx(EX_PC)]: increment when BU_Taken, saturating at 3; otherwise decrement, saturating at 0.
    - mispredict when BU_Taken != EX_Pred.
  - On mispredict:
    - Flush = 1 in the same cycle.
    - Register Redirect_PC = BU_Taken ? EX_PC + EX_Imm : EX_PC + 4. Both sums are modulo 2^XLEN (wrap, no overflow flag).
    - Increment Miss_Cnt, saturating at all-ones.
    - Next state is REDIRECT.
  - A correct prediction updates the BHT only: no Flush, no Stall.
- REDIRECT
  - Redirect_valid = 1, Stall = 1, Flush = 1.
  - BU_En = 0; EX_Branch is ignored, because it is wrong-path and flushed.
  - No BHT or Miss_Cnt update.
  - Redirect_PC is held stable until accepted.
  - When Redirect_valid && Redirect_ready, return to IDLE.
- Simultaneous BHT read at IF_PC and update at the same index: the read returns the pre-update value (no bypass).
- BU_Taken is don't-care when BU_En = 0.

## Timing
- Pred_taken, BU_En and the IDLE-state Flush are combinational; there are no latches.
- Redirect_valid, Redirect_PC and Miss_Cnt are registered.
- Mispredict detected in cycle N:
  - Flush high in cycle N.
  - Redirect_valid first high in cycle N+1.
  - If ready in N+1, state returns to IDLE in N+2; minimum redirect penalty is 2 cycles.
- Redirect_ready held low keeps REDIRECT indefinitely; Redirect_PC is unchanged throughout.
- Reset values:
  - state = IDLE, Redirect_valid = 0, Redirect_PC = 0, Miss_Cnt = 0.
  - Flush = 0, Stall = 0, all BHT entries = 2'b01.
- RST asserted mid-REDIRECT drops Redirect_valid and Stall immediately (asynchronously); the redirect is lost by design.

## Structure
- branch_pkg holds:
  - the FSM state enum (IDLE, REDIRECT);
  - the BHT counter reset constant 2'b01;
  - the funct3 branch encodings shared with the branch unit.
- One sub-module, branch_bht:
  - 2^BHT_IDX × 2-bit counter array;
  - one combinational read port (IF_PC index) and one write port with saturating update (EX_PC index, taken flag, enable);
  - async reset of all entries.
- branch_ctrl contains the FSM, target adder, redirect register and Miss_Cnt.

## Test plan
- Reset, then IF_PC=0x100 → Pred_taken=0; all outputs at reset values.
- EX_Branch=1, EX_PC=0x100, EX_Imm=0x20, EX_Pred=0, BU_Taken=1:
  - Flush=1 in the same cycle;
  - next cycle Redirect_valid=1, Redirect_PC=0x120, Stall=1;
  - Miss_Cnt=1;
  - BHT[0] goes 01→10, so Pred_taken=1 at IF_PC=0x100.
- Mispredict with Redirect_ready held low 5 cycles → Redirect_valid and Redirect_PC stable; EX_Branch pulses ignored; Miss_Cnt unchanged; IDLE one cycle after ready.
- Four taken resolutions at EX_PC=0x40 → counter saturates at 3. Then one not-taken with EX_Pred=1 → counter 2, redirect to 0x44. EX_PC=0xFFFFFFFC, EX_Imm=0x8, taken → Redirect_PC=0x4 (wrap).
- Same-cycle update and read at index 5 → Pred_taken reflects the old counter that cycle and the new counter the next.
- RST pulsed while in REDIRECT → Redirect_valid=0 immediately, state IDLE, BHT back to 01, Miss_Cnt=0.

Source files
------------

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution controller:
//   - state_e        : controller FSM states (IDLE, REDIRECT)
//   - BHT_RST_VAL    : reset value of every BHT counter (weakly not-taken)
//   - F3_*           : funct3 encodings of conditional branches, shared with
//                      the EX-stage branch unit
//   - bht_sat_update : 2-bit saturating counter step
// -----------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  localparam logic [1:0] BHT_RST_VAL = 2'b01;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Count up on taken, down on not-taken, clamped to [0,3].
  function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt,
                                                input logic       taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// -----------------------------------------------------------------------------
// branch_bht
// Direct-mapped table of 2^BHT_IDX two-bit saturating counters.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset (all entries -> 01)
//   i_rd_idx      : combinational read index (fetch lookup)
//   o_rd_cnt      : counter at i_rd_idx (pre-update value, no bypass)
//   i_wr_en       : apply a saturating update this cycle
//   i_wr_idx      : index to update
//   i_wr_taken    : direction of the update (1 = increment)
// -----------------------------------------------------------------------------
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_IDX = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BHT_IDX-1:0] i_rd_idx,
  output logic [1:0]         o_rd_cnt,
  input  logic               i_wr_en,
  input  logic [BHT_IDX-1:0] i_wr_idx,
  input  logic               i_wr_taken
);

  localparam int DEPTH = 1 << BHT_IDX;

  logic [1:0] w_cnt [DEPTH];

  // Each entry is its own register so the whole table can be reset
  // asynchronously in a single cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cnt <= BHT_RST_VAL;
      end else if (i_wr_en && (i_wr_idx == BHT_IDX'(gi))) begin
        r_cnt <= bht_sat_update(r_cnt, i_wr_taken);
      end
    end

    assign w_cnt[gi] = r_cnt;
  end

  assign o_rd_cnt = w_cnt[i_rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Branch resolution controller: BHT prediction at fetch, branch-unit gating in
// EX, mispredict detection, wrong-path flush and corrected-PC redirect to fetch
// over a valid/ready handshake.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   IF_PC / Pred_taken: fetch lookup and its prediction (combinational)
//   EX_Branch, EX_PC, EX_Imm, EX_Pred : EX-stage branch and carried prediction
//   BU_En / BU_Taken  : branch-unit enable and its decision
//   Redirect_valid/_PC/_ready : corrected PC handshake to fetch
//   Flush, Stall      : pipeline control
//   Miss_Cnt          : saturating mispredict count
// -----------------------------------------------------------------------------
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 4,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  IF_PC,
  output logic             Pred_taken,
  input  logic             EX_Branch,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic [XLEN-1:0]  EX_Imm,
  input  logic             EX_Pred,
  output logic             BU_En,
  input  logic             BU_Taken,
  output logic             Redirect_valid,
  output logic [XLEN-1:0]  Redirect_PC,
  input  logic             Redirect_ready,
  output logic             Flush,
  output logic             Stall,
  output logic [CNT_W-1:0] Miss_Cnt
);

  state_e            r_state;
  state_e            w_state_next;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [1:0]        w_rd_cnt;
  logic              w_resolve;
  logic              w_mispredict;
  logic [XLEN-1:0]   w_target;

  // Only index bits of the PCs feed the table; the rest is intentionally dropped.
  logic w_unused_if_pc;
  assign w_unused_if_pc = ^{IF_PC[XLEN-1:BHT_IDX+2], IF_PC[1:0]};

  branch_bht #(
    .BHT_IDX (BHT_IDX)
  ) u_bht (
    .CLK        (CLK),
    .RST        (RST),
    .i_rd_idx   (IF_PC[BHT_IDX+1:2]),
    .o_rd_cnt   (w_rd_cnt),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (EX_PC[BHT_IDX+1:2]),
    .i_wr_taken (BU_Taken)
  );

  assign Pred_taken = w_rd_cnt[1];

  // A branch is resolved only in IDLE; in REDIRECT the EX contents are
  // wrong-path and must not train the table or the counter.
  assign w_resolve    = (r_state == ST_IDLE) && EX_Branch;
  assign w_mispredict = w_resolve && (BU_Taken != EX_Pred);
  assign w_target     = BU_Taken ? (EX_PC + EX_Imm) : (EX_PC + XLEN'(4));

  always_comb begin
    w_state_next = r_state;
    BU_En        = 1'b0;
    Flush        = 1'b0;
    Stall        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        BU_En = EX_Branch;
        Flush = w_mispredict;
        if (w_mispredict) w_state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        Flush = 1'b1;
        Stall = 1'b1;
        if (Redirect_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      // Captured only on a mispredict, so it stays frozen for the whole
      // REDIRECT period regardless of what EX presents.
      if (w_mispredict) begin
        r_redirect_pc <= w_target;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign Redirect_valid = (r_state == ST_REDIRECT);
  assign Redirect_PC    = r_redirect_pc;
  assign Miss_Cnt       = r_miss_cnt;

endmodule
